fe_pc_gen: RTL and testbench

Fetch-side program-counter generator and instruction-memory requester for Raisin64. It consumes the redirect (`do_jump`/`jump_pc`) produced by the execute branch unit and sequences single-outstanding fetch requests to instruction memory. It delivers each fetched instruction with its `pc` and `next_pc` to decode; `next_pc` is the value later returned to execute for branch targets and link. On a redirect it flushes the held instruction and discards any in-flight stale response.

---
 rtl/fe_pc_gen_if.sv | 27 ++
 rtl/fe_pc_gen.sv | 122 ++++++++++++
 tb/tb_fe_pc_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_pc_gen_if.sv
// Fetch front-end bundle: branch redirect in, instruction memory handshake, decoded-side outputs.
// master = fe_pc_gen, slave = branch unit / instruction memory / decode environment.
interface fe_pc_gen_if;
    logic        do_jump;
    logic [63:0] jump_pc;
    logic        stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [63:0] imem_data;
    logic [1:0]  imem_len;
    logic [63:0] ir;
    logic [63:0] pc;
    logic [63:0] next_pc;
    logic        ir_valid;
    logic        fe_busy;

    modport master (
        input  do_jump, jump_pc, stall, imem_ack, imem_data, imem_len,
        output imem_req, imem_addr, ir, pc, next_pc, ir_valid, fe_busy
    );

    modport slave (
        output do_jump, jump_pc, stall, imem_ack, imem_data, imem_len,
        input  imem_req, imem_addr, ir, pc, next_pc, ir_valid, fe_busy
    );
endinterface

// File: rtl/fe_pc_gen.sv
// PC generator with single-outstanding imem fetch; ir valid the edge after ack, next request one edge later.
// stall holds a valid ir and blocks new requests; do_jump always flushes and kills any in-flight fetch.
module fe_pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    fe_pc_gen_if.master   fe
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;

    state_t      state_q,     state_d;
    logic [63:0] fetch_pc_q,  fetch_pc_d;
    logic        imem_req_q,  imem_req_d;
    logic [63:0] imem_addr_q, imem_addr_d;
    logic [63:0] ir_q,        ir_d;
    logic [63:0] pc_q,        pc_d;
    logic [63:0] next_pc_q,   next_pc_d;
    logic        ir_valid_q,  ir_valid_d;

    logic [3:0]  ilen_bytes;
    logic [63:0] seq_pc;
    logic        slot_free;

    always_comb begin
        case (fe.imem_len)
            2'b00:   ilen_bytes = 4'd2;
            2'b01:   ilen_bytes = 4'd4;
            default: ilen_bytes = 4'd8;
        endcase
    end

    // Wraps modulo 2^64 by construction.
    assign seq_pc    = fetch_pc_q + {60'd0, ilen_bytes};
    assign slot_free = !ir_valid_q || !fe.stall;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        next_pc_d   = next_pc_q;
        // A held instruction stays only while decode stalls; otherwise it is consumed.
        ir_valid_d  = ir_valid_q && fe.stall;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (!fe.do_jump && slot_free) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (fe.do_jump) begin
                    if (fe.imem_ack) begin
                        imem_req_d = 1'b0;
                        state_d    = REQ;
                    end else begin
                        state_d    = KILL;
                    end
                end else if (fe.imem_ack) begin
                    ir_d       = fe.imem_data;
                    pc_d       = fetch_pc_q;
                    next_pc_d  = seq_pc;
                    ir_valid_d = 1'b1;
                    fetch_pc_d = seq_pc;
                    imem_req_d = 1'b0;
                    state_d    = REQ;
                end
            end
            KILL: begin
                // Stale response is swallowed; the request must stay up until memory answers it.
                if (fe.imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        if (fe.do_jump) begin
            fetch_pc_d = {fe.jump_pc[63:1], 1'b0};
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REQ;
            fetch_pc_q  <= {RESET_PC[63:1], 1'b0};
            imem_req_q  <= 1'b0;
            imem_addr_q <= 64'd0;
            ir_q        <= 64'd0;
            pc_q        <= 64'd0;
            next_pc_q   <= 64'd0;
            ir_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            next_pc_q   <= next_pc_d;
            ir_valid_q  <= ir_valid_d;
        end
    end

    assign fe.imem_req  = imem_req_q;
    assign fe.imem_addr = imem_addr_q;
    assign fe.ir        = ir_q;
    assign fe.pc        = pc_q;
    assign fe.next_pc   = next_pc_q;
    assign fe.ir_valid  = ir_valid_q;
    assign fe.fe_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fe_pc_gen.sv
// Directed bench for fe_pc_gen: memory responder returns ~addr as data, monitor logs outputs and requests.
module tb_fe_pc_gen;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] npc;
        logic [63:0] ir;
    } cap_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fe_pc_gen_if bus();

    fe_pc_gen #(.RESET_PC(64'h1001)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fe    (bus.master)
    );

    int          checks = 0;
    int          errors = 0;
    int          mem_wait = 0;
    int          mem_cnt = 0;
    logic [1:0]  def_len = 2'b01;
    logic [1:0]  len_q[$];
    cap_t        cap_q[$];
    logic [63:0] addr_q[$];
    logic        prev_vld = 1'b0;
    logic        prev_req = 1'b0;

    // Memory: acks mem_wait cycles after seeing a request, data = ~addr.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = 64'd0;
            bus.imem_len  = 2'b00;
            mem_cnt       = 0;
        end else if (bus.imem_ack) begin
            bus.imem_ack = 1'b0;
            mem_cnt      = 0;
        end else if (bus.imem_req) begin
            if (mem_cnt >= mem_wait) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = ~bus.imem_addr;
                bus.imem_len  = (len_q.size() > 0) ? len_q.pop_front() : def_len;
            end else begin
                mem_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.ir_valid && !prev_vld) cap_q.push_back('{bus.pc, bus.next_pc, bus.ir});
            if (bus.imem_req && !prev_req) addr_q.push_back(bus.imem_addr);
        end
        prev_vld = bus.ir_valid;
        prev_req = bus.imem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_caps(input int base, input int n);
        int t = 0;
        while (cap_q.size() < base + n && t < 200) begin
            tick();
            t++;
        end
        checks++;
        if (cap_q.size() < base + n) begin
            errors++;
            $display("FAIL wait_caps: got %0d instructions, need %0d", cap_q.size() - base, n);
        end
    endtask

    task automatic pause();
        @(negedge clk);
        bus.stall = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] got[7];
        logic [63:0] exp[7];
        rst_n = 1'b0;
        bus.do_jump = 1'b0;
        bus.jump_pc = 64'd0;
        bus.stall   = 1'b0;
        repeat (3) tick();
        got = '{64'(bus.imem_req), bus.imem_addr, bus.ir, bus.pc, bus.next_pc,
                64'(bus.ir_valid), 64'(bus.fe_busy)};
        exp = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, got[i], exp[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_before_edge: got %b expected 0", bus.imem_req);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h1000) begin
            errors++;
            $display("FAIL first_req: req %b addr %h expected 1 / 1000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [63:0] ep;
        wait_caps(0, 3);
        for (int i = 0; i < 3; i++) begin
            ep = 64'h1000 + 64'(4 * i);
            checks++;
            if (cap_q[i].pc !== ep || cap_q[i].npc !== ep + 64'd4 || cap_q[i].ir !== ~ep) begin
                errors++;
                $display("FAIL seq[%0d]: pc %h npc %h ir %h expected pc %h npc %h ir %h",
                         i, cap_q[i].pc, cap_q[i].npc, cap_q[i].ir, ep, ep + 64'd4, ~ep);
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] ep;
        pause();
        ep = 64'h1000 + 64'(4 * (cap_q.size() - 1));
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.pc !== ep || bus.next_pc !== ep + 64'd4 ||
                bus.ir !== ~ep || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: vld %b pc %h npc %h req %b expected 1 %h %h 0",
                         c, bus.ir_valid, bus.pc, bus.next_pc, bus.imem_req, ep, ep + 64'd4);
            end
        end
        @(negedge clk);
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== ep + 64'd4 || bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: req %b addr %h vld %b expected 1 %h 0",
                     bus.imem_req, bus.imem_addr, bus.ir_valid, ep + 64'd4);
        end
        pause();
    endtask

    task automatic test_mixed_len();
        logic [63:0] ep[3];
        logic [63:0] en[3];
        int base;
        ep = '{64'h0, 64'h2, 64'hA};
        en = '{64'h2, 64'hA, 64'hE};
        len_q.push_back(2'b00);
        len_q.push_back(2'b10);
        len_q.push_back(2'b01);
        base = cap_q.size();
        @(negedge clk);
        bus.do_jump = 1'b1;
        bus.jump_pc = 64'h0;
        tick();
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL jump_flush_req: vld %b req %b expected 0 0", bus.ir_valid, bus.imem_req);
        end
        @(negedge clk);
        bus.do_jump = 1'b0;
        bus.stall   = 1'b0;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL jump_issue: req %b addr %h expected 1 0", bus.imem_req, bus.imem_addr);
        end
        wait_caps(base, 3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap_q[base+i].pc !== ep[i] || cap_q[base+i].npc !== en[i]) begin
                errors++;
                $display("FAIL mixed[%0d]: pc %h npc %h expected %h %h",
                         i, cap_q[base+i].pc, cap_q[base+i].npc, ep[i], en[i]);
            end
        end
        pause();
    endtask

    task automatic test_kill();
        logic [63:0] stale;
        int base;
        int t;
        mem_wait = 3;
        base = cap_q.size();
        @(negedge clk);
        bus.stall = 1'b0;
        tick();
        stale = bus.imem_addr;
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL kill_issue: req %b expected 1", bus.imem_req);
        end
        @(negedge clk);
        bus.do_jump = 1'b1;
        bus.jump_pc = 64'h2001;
        tick();
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== stale) begin
            errors++;
            $display("FAIL kill_hold: vld %b req %b addr %h expected 0 1 %h",
                     bus.ir_valid, bus.imem_req, bus.imem_addr, stale);
        end
        @(negedge clk);
        bus.do_jump = 1'b0;
        t = 0;
        while (bus.imem_req === 1'b1 && t < 20) begin
            tick();
            t++;
            if (bus.imem_req === 1'b1) begin
                checks++;
                if (bus.imem_addr !== stale) begin
                    errors++;
                    $display("FAIL kill_addr_stable: addr %h expected %h", bus.imem_addr, stale);
                end
            end
        end
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL kill_drop: req %b expected 0 after stale ack", bus.imem_req);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h2000) begin
            errors++;
            $display("FAIL kill_redirect: req %b addr %h expected 1 2000", bus.imem_req, bus.imem_addr);
        end
        wait_caps(base, 1);
        checks++;
        if (cap_q[base].pc !== 64'h2000 || cap_q[base].npc !== 64'h2004 || cap_q[base].ir !== ~64'h2000) begin
            errors++;
            $display("FAIL kill_first: pc %h npc %h ir %h expected 2000 2004 %h",
                     cap_q[base].pc, cap_q[base].npc, cap_q[base].ir, ~64'h2000);
        end
        pause();
    endtask

    task automatic test_jump_with_ack();
        int base;
        mem_wait = 0;
        base = cap_q.size();
        @(negedge clk);
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL coinc_issue: req %b expected 1", bus.imem_req);
        end
        @(negedge clk);
        bus.do_jump = 1'b1;
        bus.jump_pc = 64'h3000;
        tick();
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL coinc_discard: vld %b req %b expected 0 0", bus.ir_valid, bus.imem_req);
        end
        @(negedge clk);
        bus.do_jump = 1'b0;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h3000) begin
            errors++;
            $display("FAIL coinc_redirect: req %b addr %h expected 1 3000", bus.imem_req, bus.imem_addr);
        end
        wait_caps(base, 1);
        checks++;
        if (cap_q[base].pc !== 64'h3000 || cap_q[base].ir !== ~64'h3000) begin
            errors++;
            $display("FAIL coinc_first: pc %h ir %h expected 3000 %h", cap_q[base].pc, cap_q[base].ir, ~64'h3000);
        end
        pause();
    endtask

    task automatic test_wrap();
        int base;
        int abase;
        def_len = 2'b10;
        base  = cap_q.size();
        abase = addr_q.size();
        @(negedge clk);
        bus.do_jump = 1'b1;
        bus.jump_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        bus.do_jump = 1'b0;
        bus.stall   = 1'b0;
        wait_caps(base, 2);
        checks++;
        if (cap_q[base].pc !== 64'hFFFF_FFFF_FFFF_FFF8 || cap_q[base].npc !== 64'h0) begin
            errors++;
            $display("FAIL wrap_npc: pc %h npc %h expected fffffffffffffff8 0", cap_q[base].pc, cap_q[base].npc);
        end
        checks++;
        if (cap_q[base+1].pc !== 64'h0 || cap_q[base+1].npc !== 64'h8) begin
            errors++;
            $display("FAIL wrap_next: pc %h npc %h expected 0 8", cap_q[base+1].pc, cap_q[base+1].npc);
        end
        checks++;
        if (addr_q.size() < abase + 2 || addr_q[abase+1] !== 64'h0) begin
            errors++;
            $display("FAIL wrap_addr: requests %0d, second addr %h expected 0",
                     addr_q.size() - abase, (addr_q.size() >= abase + 2) ? addr_q[abase+1] : 64'hx);
        end
        pause();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_mixed_len();
        test_kill();
        test_jump_with_ack();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
